// File: rtl/iir_output_capture_if.sv
// Drain-side handshake for iir_output_capture: FWFT head word plus valid/ready pop.
interface iir_output_capture_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              cap_ready;

  modport master (output cap_valid, output cap_data, input cap_ready);
  modport slave  (input cap_valid, input cap_data, output cap_ready);
endinterface

// File: rtl/iir_output_capture.sv
// Captures a window of IIR outData samples into a FWFT FIFO after a settling skip.
// Optional running checksum of written samples under `IIR_CAPTURE_CKSUM_EN.
module iir_output_capture #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SKIP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SKIP_W-1:0]      skip_count,
  input  logic [CNT_W-1:0]       sample_count,
  input  logic [DATA_W-1:0]      outData,
  iir_output_capture_if.master   cap,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [DATA_W-1:0]      cksum
);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SKIP    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [AW-1:0] IDX_ONE  = 1;
  localparam logic [AW:0]   FILL_ONE = 1;

  logic [1:0]        state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [CNT_W-1:0]  samp_cnt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [AW-1:0]     rd_next;
  logic [DATA_W-1:0] head_q, head_d;
  logic              empty, full, pop, push_req, push;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && cap.cap_ready;
  assign push_req = (state == ST_CAPTURE);
  // A push into a full FIFO still lands when the head is popped on the same edge.
  assign push     = push_req && (!full || pop);
  assign rd_next  = rd_ptr[AW-1:0] + IDX_ONE;

  assign fill_level    = wr_ptr - rd_ptr;
  assign cap.cap_valid = !empty;
  assign cap.cap_data  = head_q;

  // Head register keeps the last popped word visible once the FIFO runs empty.
  always_comb begin
    head_d = head_q;
    if (push && (empty || (pop && fill_level == FILL_ONE))) begin
      head_d = outData;
    end else if (pop && fill_level > FILL_ONE) begin
      head_d = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= outData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      samp_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      head_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done   <= 1'b0;
      head_q <= head_d;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_req && full && !pop) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            skip_cnt <= skip_count;
            samp_cnt <= sample_count;
            overflow <= 1'b0;
            if (sample_count == '0) begin
              done <= 1'b1;
            end else if (skip_count == '0) begin
              state <= ST_CAPTURE;
              busy  <= 1'b1;
            end else begin
              state <= ST_SKIP;
              busy  <= 1'b1;
            end
          end
        end
        ST_SKIP: begin
          skip_cnt <= skip_cnt - SKIP_W'(1);
          if (skip_cnt == SKIP_W'(1)) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          samp_cnt <= samp_cnt - CNT_W'(1);
          if (samp_cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IIR_CAPTURE_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cksum_q <= '0;
    end else if (state == ST_IDLE && start) begin
      cksum_q <= '0;
    end else if (push) begin
      cksum_q <= cksum_q + outData;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_iir_output_capture.sv
// Directed bench for iir_output_capture: table of capture windows plus corner sequences.
module tb_iir_output_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  skip_count = '0;
  logic [15:0] sample_count = '0;
  logic [31:0] out_data;
  logic        busy, done, overflow;
  logic [4:0]  fill_level;
  logic [31:0] cksum;

  logic [31:0] cyc = '0;
  logic        use_man = 1'b0;
  logic [31:0] man_val = '0;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] popq[$];

  iir_output_capture_if #(.DATA_W(32)) cap_if ();

  iir_output_capture #(.DATA_W(32), .DEPTH(16), .CNT_W(16), .SKIP_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .skip_count   (skip_count),
    .sample_count (sample_count),
    .outData      (out_data),
    .cap          (cap_if.master),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .fill_level   (fill_level),
    .cksum        (cksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign out_data = use_man ? man_val : 32'd100 + cyc;

  always @(negedge clk) begin
    if (cap_if.cap_valid && cap_if.cap_ready) popq.push_back(cap_if.cap_data);
  end

  typedef struct {
    int skip;
    int n;
    bit ready;
    int exp_done;
    int exp_busy;
    int exp_fill;
    bit exp_ovf;
    int keep;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    start = 1'b0;
    cap_if.cap_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    popq.delete();
  endtask

  // Returns just after the accepting edge E0; out_data at edge E0+k is 100+e0+k-1.
  task automatic do_start(input int s, input int n, output logic [31:0] e0);
    @(posedge clk);
    #1;
    start = 1'b1;
    skip_count = 8'(s);
    sample_count = 16'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic drain();
    @(posedge clk);
    #1 cap_if.cap_ready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (!cap_if.cap_valid) break;
    end
  endtask

  initial begin
    logic [31:0] e0;
    logic [31:0] sum;
    int done_at, busy_n, done_n, fill_at, ovf_at;
    logic [31:0] ck_at;
    logic [31:0] full_exp[19];

    vecs[0] = '{skip: 0, n: 4,  ready: 1'b1, exp_done: 5,  exp_busy: 4,  exp_fill: 1,
                exp_ovf: 1'b0, keep: 4};
    vecs[1] = '{skip: 3, n: 2,  ready: 1'b1, exp_done: 6,  exp_busy: 5,  exp_fill: 1,
                exp_ovf: 1'b0, keep: 2};
    vecs[2] = '{skip: 0, n: 20, ready: 1'b0, exp_done: 21, exp_busy: 20, exp_fill: 16,
                exp_ovf: 1'b1, keep: 16};
    vecs[3] = '{skip: 2, n: 0,  ready: 1'b1, exp_done: 1,  exp_busy: 0,  exp_fill: 0,
                exp_ovf: 1'b0, keep: 0};
    vecs[4] = '{skip: 1, n: 16, ready: 1'b0, exp_done: 18, exp_busy: 17, exp_fill: 16,
                exp_ovf: 1'b0, keep: 16};
    vecs[5] = '{skip: 5, n: 3,  ready: 1'b0, exp_done: 9,  exp_busy: 8,  exp_fill: 3,
                exp_ovf: 1'b0, keep: 3};

    cap_if.cap_ready = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_valid", cap_if.cap_valid, 0);
    chk("rst_data", cap_if.cap_data, 0);
    chk("rst_cksum", cksum, 0);

    for (int v = 0; v < 6; v++) begin
      apply_reset();
      cap_if.cap_ready = vecs[v].ready;
      do_start(vecs[v].skip, vecs[v].n, e0);
      done_at = 0; busy_n = 0; done_n = 0; fill_at = -1; ovf_at = -1; ck_at = '0;
      for (int j = 1; j <= 40; j++) begin
        @(negedge clk);
        if (busy) busy_n++;
        if (done) begin
          done_n++;
          if (done_at == 0) begin
            done_at = j; fill_at = int'(fill_level); ovf_at = int'(overflow); ck_at = cksum;
          end
        end
      end
      sum = '0;
      for (int i = 0; i < vecs[v].keep; i++) sum += 32'd100 + e0 + 32'(vecs[v].skip + i);
`ifndef IIR_CAPTURE_CKSUM_EN
      sum = '0;
`endif
      chk($sformatf("v%0d_done_cycle", v), done_at, vecs[v].exp_done);
      chk($sformatf("v%0d_done_pulses", v), done_n, 1);
      chk($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].exp_busy);
      chk($sformatf("v%0d_fill_at_done", v), fill_at, vecs[v].exp_fill);
      chk($sformatf("v%0d_ovf_at_done", v), ovf_at, vecs[v].exp_ovf);
      chk($sformatf("v%0d_cksum", v), ck_at, sum);
      if (!vecs[v].ready) drain();
      chk($sformatf("v%0d_valid_after", v), cap_if.cap_valid, 0);
      chk($sformatf("v%0d_fill_after", v), fill_level, 0);
      chk($sformatf("v%0d_pop_count", v), popq.size(), vecs[v].keep);
      for (int i = 0; i < vecs[v].keep && i < popq.size(); i++)
        chk($sformatf("v%0d_data%0d", v, i), popq[i], 32'd100 + e0 + 32'(vecs[v].skip + i));
    end

    // Full FIFO, consumer wakes up mid-capture: one drop, then push+pop at full.
    apply_reset();
    do_start(0, 20, e0);
    for (int j = 1; j <= 17; j++) @(negedge clk);
    chk("full_fill16", fill_level, 16);
    chk("full_ovf_before", overflow, 0);
    @(posedge clk);
    #1;
    chk("full_ovf_set", overflow, 1);
    cap_if.cap_ready = 1'b1;
    done_n = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done) done_n++;
      if (j > 0) chk("full_fill_steady", fill_level, busy || done ? 16 : fill_level);
    end
    chk("full_done", done_n, 1);
    drain();
    chk("full_ovf_sticky", overflow, 1);
    for (int i = 0; i < 16; i++) full_exp[i] = 32'd100 + e0 + 32'(i);
    for (int i = 16; i < 19; i++) full_exp[i] = 32'd101 + e0 + 32'(i);
    chk("full_pop_count", popq.size(), 19);
    for (int i = 0; i < 19 && i < popq.size(); i++)
      chk($sformatf("full_data%0d", i), popq[i], full_exp[i]);

    // A start while busy must not retrigger or extend the capture.
    apply_reset();
    cap_if.cap_ready = 1'b1;
    do_start(0, 3, e0);
    start = 1'b1;
    sample_count = 16'd10;
    @(posedge clk);
    #1 start = 1'b0;
    done_n = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("busy_start_done", done_n, 1);
    chk("busy_start_idle", busy, 0);
    chk("busy_start_pops", popq.size(), 3);
    for (int i = 0; i < 3 && i < popq.size(); i++)
      chk($sformatf("busy_start_data%0d", i), popq[i], 32'd100 + e0 + 32'(i));

    // Asynchronous reset in the middle of a capture.
    apply_reset();
    do_start(0, 10, e0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_fill_pre", fill_level, 4);
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fill", fill_level, 0);
    chk("mid_rst_valid", cap_if.cap_valid, 0);
    chk("mid_rst_data", cap_if.cap_data, 0);
    chk("mid_rst_cksum", cksum, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    done_n = 0; busy_n = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (done) done_n++;
      if (busy) busy_n++;
    end
    chk("mid_no_done", done_n, 0);
    chk("mid_no_busy", busy_n, 0);

    // Checksum over samples 1,2,3.
    apply_reset();
    use_man = 1'b1;
    do_start(0, 3, e0);
    man_val = 32'd1;
    @(posedge clk);
    #1 man_val = 32'd2;
    @(posedge clk);
    #1 man_val = 32'd3;
    @(posedge clk);
    #1;
    chk("ck_done", done, 1);
    chk("ck_fill", fill_level, 3);
`ifdef IIR_CAPTURE_CKSUM_EN
    chk("ck_sum", cksum, 6);
`else
    chk("ck_sum", cksum, 0);
`endif
    use_man = 1'b0;
    drain();
    chk("ck_pop_count", popq.size(), 3);
    for (int i = 0; i < 3 && i < popq.size(); i++)
      chk($sformatf("ck_data%0d", i), popq[i], 32'(i + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
